// File: rtl/key_digit_accumulator.sv
// Turns debounced keypad presses into edits of a 4-digit BCD entry buffer.
// Each press yields exactly one edit: digit shift-in, clear (key 10) or backspace (key 11).
module key_digit_accumulator #(
    parameter int unsigned RELEASE_CYCLES = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Found,
    input  logic [3:0] OnesDigit,
    input  logic [3:0] TensDigit,
    output logic [3:0] Digit0,
    output logic [3:0] Digit1,
    output logic [3:0] Digit2,
    output logic [3:0] Digit3,
    output logic [2:0] DigitCount,
    output logic       Full,
    output logic       KeyStrobe
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAccept  = 2'd1;
    localparam logic [1:0] StHeld    = 2'd2;
    localparam logic [1:0] StRelease = 2'd3;

    localparam logic [7:0] RelLimit = 8'(RELEASE_CYCLES);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] key_q, key_d;
    logic       valid_q, valid_d;
    logic [3:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [2:0] count_q, count_d;
    logic       full_q, full_d;
    logic       strobe_q, strobe_d;

    logic [4:0] key_code;
    logic       key_valid;

    // Truncation to 5 bits can alias a large code onto a small one, so validity
    // is judged from the raw digits as well and captured alongside the code.
    assign key_code  = 5'({1'b0, TensDigit} * 5'd10) + {1'b0, OnesDigit};
    assign key_valid = (TensDigit <= 4'd1) && (OnesDigit <= 4'd9) && (key_code <= 5'd15);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        valid_d  = valid_q;
        d0_d     = d0_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        d3_d     = d3_q;
        count_d  = count_q;
        strobe_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (Found) begin
                    key_d   = key_code;
                    valid_d = key_valid;
                    state_d = StAccept;
                end
            end
            StAccept: begin
                state_d = StHeld;
                if (valid_q) begin
                    strobe_d = 1'b1;
                    if (key_q <= 5'd9) begin
                        if (count_q != 3'd4) begin
                            d3_d    = d2_q;
                            d2_d    = d1_q;
                            d1_d    = d0_q;
                            d0_d    = key_q[3:0];
                            count_d = count_q + 3'd1;
                        end
                    end else if (key_q == 5'd10) begin
                        d0_d    = 4'd0;
                        d1_d    = 4'd0;
                        d2_d    = 4'd0;
                        d3_d    = 4'd0;
                        count_d = 3'd0;
                    end else if (key_q == 5'd11) begin
                        if (count_q != 3'd0) begin
                            d0_d    = d1_q;
                            d1_d    = d2_q;
                            d2_d    = d3_q;
                            d3_d    = 4'd0;
                            count_d = count_q - 3'd1;
                        end
                    end
                end
            end
            StHeld: begin
                if (!Found) begin
                    if (RelLimit == 8'd1) begin
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = StRelease;
                        cnt_d   = 8'd1;
                    end
                end
            end
            default: begin
                if (Found) begin
                    state_d = StHeld;
                    cnt_d   = 8'd0;
                end else if (cnt_q + 8'd1 == RelLimit) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase

        full_d = (count_d == 3'd4);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            key_q    <= 5'd0;
            valid_q  <= 1'b0;
            d0_q     <= 4'd0;
            d1_q     <= 4'd0;
            d2_q     <= 4'd0;
            d3_q     <= 4'd0;
            count_q  <= 3'd0;
            full_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            d3_q     <= d3_d;
            count_q  <= count_d;
            full_q   <= full_d;
            strobe_q <= strobe_d;
        end
    end

    assign Digit0     = d0_q;
    assign Digit1     = d1_q;
    assign Digit2     = d2_q;
    assign Digit3     = d3_q;
    assign DigitCount = count_q;
    assign Full       = full_q;
    assign KeyStrobe  = strobe_q;

endmodule

// File: tb/tb_key_digit_accumulator.sv
// Directed bench for key_digit_accumulator: entry, overflow, edit keys, bounce,
// invalid codes and reset mid-press, all with hand-computed expectations.
module tb_key_digit_accumulator;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Found = 1'b0;
    logic [3:0] OnesDigit = 4'd0;
    logic [3:0] TensDigit = 4'd0;
    logic [3:0] Digit0, Digit1, Digit2, Digit3;
    logic [2:0] DigitCount;
    logic       Full;
    logic       KeyStrobe;

    int checks = 0;
    int passed = 0;
    int failed = 0;
    int strobes = 0;
    int s0;

    key_digit_accumulator #(.RELEASE_CYCLES(16)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Found     (Found),
        .OnesDigit (OnesDigit),
        .TensDigit (TensDigit),
        .Digit0    (Digit0),
        .Digit1    (Digit1),
        .Digit2    (Digit2),
        .Digit3    (Digit3),
        .DigitCount(DigitCount),
        .Full      (Full),
        .KeyStrobe (KeyStrobe)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) if (KeyStrobe === 1'b1) strobes <= strobes + 1;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] t, input logic [3:0] o, input int hi, input int lo);
        TensDigit = t;
        OnesDigit = o;
        Found = 1'b1;
        cyc(hi);
        Found = 1'b0;
        cyc(lo);
    endtask

    function automatic logic [15:0] digits();
        return {Digit3, Digit2, Digit1, Digit0};
    endfunction

    initial begin
        // Reset state
        cyc(2);
        check("rst_digits", 32'(digits()), 32'h0000);
        check("rst_count", 32'(DigitCount), 32'd0);
        check("rst_full", 32'(Full), 32'd0);
        check("rst_strobe", 32'(KeyStrobe), 32'd0);
        Reset = 1'b0;
        cyc(1);

        // Key 1 with latency checks
        s0 = strobes;
        TensDigit = 4'd0;
        OnesDigit = 4'd1;
        Found = 1'b1;
        cyc(1);
        check("lat_k_digits", 32'(digits()), 32'h0000);
        check("lat_k_strobe", 32'(KeyStrobe), 32'd0);
        cyc(1);
        check("lat_k1_digits", 32'(digits()), 32'h0001);
        check("lat_k1_count", 32'(DigitCount), 32'd1);
        check("lat_k1_strobe", 32'(KeyStrobe), 32'd1);
        cyc(1);
        check("lat_k2_strobe", 32'(KeyStrobe), 32'd0);
        cyc(47);
        Found = 1'b0;
        cyc(40);
        press(4'd0, 4'd2, 50, 40);
        press(4'd0, 4'd3, 50, 40);
        check("e123_digits", 32'(digits()), 32'h0123);
        check("e123_count", 32'(DigitCount), 32'd3);
        check("e123_strobes", 32'(strobes - s0), 32'd3);

        // Clear, then fill to four digits and overflow
        press(4'd1, 4'd0, 10, 20);
        check("clr_digits", 32'(digits()), 32'h0000);
        press(4'd0, 4'd4, 10, 20);
        press(4'd0, 4'd5, 10, 20);
        press(4'd0, 4'd6, 10, 20);
        press(4'd0, 4'd7, 10, 20);
        check("full_digits", 32'(digits()), 32'h4567);
        check("full_count", 32'(DigitCount), 32'd4);
        check("full_flag", 32'(Full), 32'd1);
        s0 = strobes;
        press(4'd0, 4'd8, 10, 20);
        check("ovf_strobe", 32'(strobes - s0), 32'd1);
        check("ovf_digits", 32'(digits()), 32'h4567);
        check("ovf_count", 32'(DigitCount), 32'd4);

        // Backspace twice, clear, backspace at empty
        press(4'd1, 4'd1, 10, 20);
        press(4'd1, 4'd1, 10, 20);
        check("bs_digits", 32'(digits()), 32'h0045);
        check("bs_count", 32'(DigitCount), 32'd2);
        check("bs_full", 32'(Full), 32'd0);
        press(4'd1, 4'd0, 10, 20);
        check("clr2_digits", 32'(digits()), 32'h0000);
        check("clr2_count", 32'(DigitCount), 32'd0);
        s0 = strobes;
        press(4'd1, 4'd1, 10, 20);
        check("bs0_digits", 32'(digits()), 32'h0000);
        check("bs0_count", 32'(DigitCount), 32'd0);
        check("bs0_strobe", 32'(strobes - s0), 32'd1);

        // Bounce pattern is one press
        s0 = strobes;
        TensDigit = 4'd0;
        OnesDigit = 4'd9;
        Found = 1'b1; cyc(20);
        Found = 1'b0; cyc(5);
        Found = 1'b1; cyc(3);
        Found = 1'b0; cyc(5);
        Found = 1'b1; cyc(20);
        Found = 1'b0; cyc(16);
        check("bnc_strobes", 32'(strobes - s0), 32'd1);
        check("bnc_digits", 32'(digits()), 32'h0009);

        // 15 low samples then high: still the same press
        s0 = strobes;
        OnesDigit = 4'd2;
        Found = 1'b1; cyc(10);
        Found = 1'b0; cyc(15);
        Found = 1'b1; cyc(10);
        Found = 1'b0; cyc(16);
        check("rel15_strobes", 32'(strobes - s0), 32'd1);
        check("rel15_digits", 32'(digits()), 32'h0092);
        s0 = strobes;
        press(4'd0, 4'd3, 10, 20);
        check("rel16_strobes", 32'(strobes - s0), 32'd1);
        check("rel16_digits", 32'(digits()), 32'h0923);

        // Invalid and non-digit codes
        s0 = strobes;
        press(4'd1, 4'd6, 10, 20);
        check("inv16_strobes", 32'(strobes - s0), 32'd0);
        check("inv16_digits", 32'(digits()), 32'h0923);
        press(4'd1, 4'd3, 10, 20);
        check("k13_strobes", 32'(strobes - s0), 32'd1);
        check("k13_digits", 32'(digits()), 32'h0923);
        press(4'd2, 4'd0, 10, 20);
        check("t2_strobes", 32'(strobes - s0), 32'd1);
        // 3*10+2 wraps to 0 in five bits; must still be rejected
        press(4'd3, 4'd2, 10, 20);
        check("wrap_strobes", 32'(strobes - s0), 32'd1);
        check("wrap_digits", 32'(digits()), 32'h0923);
        check("wrap_count", 32'(DigitCount), 32'd3);

        // Reset while held, release reset with Found still high
        TensDigit = 4'd1;
        OnesDigit = 4'd4;
        Found = 1'b1;
        cyc(5);
        Reset = 1'b1;
        cyc(1);
        check("rsth_digits", 32'(digits()), 32'h0000);
        check("rsth_count", 32'(DigitCount), 32'd0);
        check("rsth_full", 32'(Full), 32'd0);
        check("rsth_strobe", 32'(KeyStrobe), 32'd0);
        TensDigit = 4'd0;
        OnesDigit = 4'd7;
        Reset = 1'b0;
        s0 = strobes;
        cyc(2);
        check("rstp_digits", 32'(digits()), 32'h0007);
        check("rstp_strobe", 32'(KeyStrobe), 32'd1);
        cyc(30);
        Found = 1'b0;
        cyc(20);
        check("rstp_strobes", 32'(strobes - s0), 32'd1);
        check("rstp_count", 32'(DigitCount), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
